// File: rtl/pic_control_sequencer_pkg.sv
// Shared encodings and command-byte field positions for the 8259A control sequencer.
package pic_control_sequencer_pkg;

   typedef enum logic [2:0] {
      UNINIT    = 3'd0,
      WAIT_ICW2 = 3'd1,
      WAIT_ICW3 = 3'd2,
      WAIT_ICW4 = 3'd3,
      READY     = 3'd4
   } init_state_t;

   typedef enum logic [1:0] {
      A_IDLE = 2'd0,
      A_P1   = 2'd1,
      A_P2   = 2'd2
   } inta_state_t;

   // ICW1 bit positions
   localparam int ICW1_FLAG = 4;
   localparam int ICW1_LTIM = 3;
   localparam int ICW1_SNGL = 1;
   localparam int ICW1_IC4  = 0;

   // ICW4 automatic-EOI bit
   localparam int ICW4_AEOI = 1;

   // OCW2 field positions
   localparam int OCW2_R     = 7;
   localparam int OCW2_SL    = 6;
   localparam int OCW2_EOI   = 5;
   localparam int OCW2_L_MSB = 2;
   localparam int OCW2_L_LSB = 0;

   // OCW3 read-register bits
   localparam int OCW3_RR  = 1;
   localparam int OCW3_RIS = 0;

   localparam logic [7:0] IMR_RESET = 8'hFF;

   // Rebuild an OCW2 byte from its fields; the command-type bits 4:3 are 00 by decode.
   function automatic logic [7:0] ocw2_cmd(input logic [7:0] d);
      return {d[OCW2_R], d[OCW2_SL], d[OCW2_EOI], 2'b00, d[OCW2_L_MSB:OCW2_L_LSB]};
   endfunction

endpackage

// File: rtl/pic_control_sequencer_inta.sv
// Two-pulse 8086 INTA sequencer: edge detect, vector latch on pulse 1, bus drive on pulse 2.
module pic_inta_sequencer
   import pic_control_sequencer_pkg::*;
#(
   parameter int VEC_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             abort,
   input  logic             ready,
   input  logic             inta,
   input  logic [VEC_W-1:0] int_vec,
   input  logic [4:0]       t_base,
   output logic             drive,
   output logic [7:0]       vec_byte
);

   inta_state_t      state, state_n;
   logic             inta_q;
   logic             inta_rise;
   logic [VEC_W-1:0] vec_q;

   assign inta_rise = inta & ~inta_q;

   // INTA history for edge detect; keeps tracking across aborts so no false edge appears
   always_ff @(posedge clk) begin
      if (rst) inta_q <= 1'b0;
      else     inta_q <= inta;
   end

   // state register; an ICW1 abort returns the sequence to idle
   always_ff @(posedge clk) begin
      if (rst || abort) state <= A_IDLE;
      else              state <= state_n;
   end

   // next-state: first edge arms, second edge drives, falling INTA releases
   always_comb begin
      state_n = state;
      case (state)
         A_IDLE:  if (inta_rise && ready) state_n = A_P1;
         A_P1:    if (inta_rise)          state_n = A_P2;
         A_P2:    if (!inta)              state_n = A_IDLE;
         default: state_n = A_IDLE;
      endcase
   end

   // vector latch and registered bus drive
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         vec_q    <= '0;
         drive    <= 1'b0;
         vec_byte <= 8'h00;
      end else begin
         if (state == A_IDLE && inta_rise && ready)
            vec_q <= int_vec;
         if (state == A_P1 && inta_rise) begin
            drive    <= 1'b1;
            vec_byte <= 8'({t_base, vec_q});
         end else if (state == A_P2 && !inta) begin
            drive    <= 1'b0;
            vec_byte <= 8'h00;
         end
      end
   end

endmodule

// File: rtl/pic_control_sequencer.sv
// 8259A command/acknowledge controller: ICW init FSM, OCW decode, INT gating, INTA vector drive.
// Optional status readback of IMR/IRR/ISR is compiled in with PIC_READBACK_EN.
module pic_control_sequencer
   import pic_control_sequencer_pkg::*;
#(
   parameter int VEC_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic             rd,
   input  logic             a0,
   input  logic [7:0]       din,
   input  logic             inta,
   input  logic             int_req,
   input  logic [VEC_W-1:0] int_vec,
   input  logic [7:0]       irr,
   input  logic [7:0]       isr,
   output logic [7:0]       im,
   output logic [7:0]       operation,
   output logic             ltim,
   output logic             aeoi,
   output logic             int_out,
   output logic [7:0]       dout,
   output logic             dout_en,
   output logic             init_done
);

   init_state_t state, state_n;
   logic        icw1;
   logic        ready;
   logic        sngl, ic4;
   logic [4:0]  t_base;
   logic [7:0]  cas_byte;
   logic        rsel;
   logic        inta_drive;
   logic [7:0]  inta_byte;
   logic        rb_en;
   logic [7:0]  rb_data;
   logic        unused_bits;

   // ICW1 is recognised in every state and always restarts initialisation
   assign icw1  = wr && !a0 && din[ICW1_FLAG];
   assign ready = (state == READY);

   // init FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= UNINIT;
      else     state <= state_n;
   end

   // init FSM next-state: ICW2 always, ICW3 only in cascade mode, ICW4 only when requested
   always_comb begin
      state_n = state;
      if (icw1) begin
         state_n = WAIT_ICW2;
      end else if (wr && a0) begin
         case (state)
            WAIT_ICW2: state_n = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
            WAIT_ICW3: state_n = ic4 ? WAIT_ICW4 : READY;
            WAIT_ICW4: state_n = READY;
            default:   state_n = state;
         endcase
      end
   end

   // configuration registers, OCW decode and INT gating
   always_ff @(posedge clk) begin
      if (rst) begin
         im        <= IMR_RESET;
         operation <= 8'h00;
         ltim      <= 1'b0;
         aeoi      <= 1'b0;
         sngl      <= 1'b0;
         ic4       <= 1'b0;
         t_base    <= 5'd0;
         cas_byte  <= 8'h00;
         rsel      <= 1'b0;
         init_done <= 1'b0;
         int_out   <= 1'b0;
      end else begin
         init_done <= (state_n == READY);
         int_out   <= int_req && ready;
         // EOI-class commands are one-cycle pulses; rotate/priority commands persist
         if (operation[OCW2_EOI]) operation <= 8'h00;
         if (icw1) begin
            ltim      <= din[ICW1_LTIM];
            sngl      <= din[ICW1_SNGL];
            ic4       <= din[ICW1_IC4];
            im        <= IMR_RESET;
            operation <= 8'h00;
            aeoi      <= 1'b0;
         end else if (wr && a0) begin
            case (state)
               WAIT_ICW2: t_base   <= din[7:3];
               WAIT_ICW3: cas_byte <= din;
               WAIT_ICW4: aeoi     <= din[ICW4_AEOI];
               READY:     im       <= din;
               default:   ;
            endcase
         end else if (wr && ready) begin
            if (din[4:3] == 2'b00)
               operation <= ocw2_cmd(din);
            else if (din[4:3] == 2'b01 && din[OCW3_RR])
               rsel <= din[OCW3_RIS];
         end
      end
   end

   pic_inta_sequencer #(.VEC_W(VEC_W)) u_inta (
      .clk      (clk),
      .rst      (rst),
      .abort    (icw1),
      .ready    (ready),
      .inta     (inta),
      .int_vec  (int_vec),
      .t_base   (t_base),
      .drive    (inta_drive),
      .vec_byte (inta_byte)
   );

`ifdef PIC_READBACK_EN
   // status read: one-cycle registered response, suppressed while INTA owns the bus
   always_ff @(posedge clk) begin
      if (rst || icw1) begin
         rb_en   <= 1'b0;
         rb_data <= 8'h00;
      end else if (rd && ready && !inta_drive) begin
         rb_en   <= 1'b1;
         rb_data <= a0 ? im : (rsel ? isr : irr);
      end else begin
         rb_en   <= 1'b0;
         rb_data <= 8'h00;
      end
   end
   assign unused_bits = ^cas_byte;
`else
   assign rb_en       = 1'b0;
   assign rb_data     = 8'h00;
   assign unused_bits = ^{cas_byte, rd, irr, isr, rsel};
`endif

   // INTA drive always wins the bus
   assign dout_en = inta_drive | rb_en;
   assign dout    = inta_drive ? inta_byte : rb_data;

endmodule

// File: tb/tb_pic_control_sequencer.sv
// Directed self-checking bench for pic_control_sequencer.
module tb_pic_control_sequencer;

   logic       clk = 1'b0;
   logic       rst, wr, rd, a0, inta, int_req;
   logic [7:0] din, irr, isr;
   logic [2:0] int_vec;
   logic [7:0] im, operation, dout;
   logic       ltim, aeoi, int_out, dout_en, init_done;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pic_control_sequencer #(.VEC_W(3)) dut (
      .clk(clk), .rst(rst), .wr(wr), .rd(rd), .a0(a0), .din(din),
      .inta(inta), .int_req(int_req), .int_vec(int_vec), .irr(irr), .isr(isr),
      .im(im), .operation(operation), .ltim(ltim), .aeoi(aeoi), .int_out(int_out),
      .dout(dout), .dout_en(dout_en), .init_done(init_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one write cycle; returns at the negedge after the write has been clocked in
   task automatic bus_wr(input logic addr, input logic [7:0] data);
      @(negedge clk);
      wr = 1'b1; a0 = addr; din = data;
      @(negedge clk);
      wr = 1'b0;
   endtask

   // one INTA pulse of 'hi' cycles; checks drive state during and after the pulse
   task automatic pulse(input string tag, input int hi, input bit drv, input logic [7:0] vec);
      @(negedge clk);
      inta = 1'b1;
      for (int i = 0; i < hi; i++) begin
         @(negedge clk);
         chk({tag, "_en"}, dout_en, drv);
         if (drv) chk({tag, "_dout"}, dout, vec);
      end
      inta = 1'b0;
      @(negedge clk);
      chk({tag, "_rel_en"}, dout_en, 1'b0);
      chk({tag, "_rel_dout"}, dout, 8'h00);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; wr = 0; rd = 0; a0 = 0; din = 0; inta = 0;
      int_req = 0; int_vec = 0; irr = 0; isr = 0;
      repeat (3) @(negedge clk);
      chk("rst_im", im, 8'hFF);
      chk("rst_op", operation, 8'h00);
      chk("rst_ltim", ltim, 1'b0);
      chk("rst_aeoi", aeoi, 1'b0);
      chk("rst_int", int_out, 1'b0);
      chk("rst_dout", dout, 8'h00);
      chk("rst_douten", dout_en, 1'b0);
      chk("rst_done", init_done, 1'b0);
      rst = 1'b0;

      // init: ICW1 1B (LTIM, single, IC4), ICW2 40, ICW4 03 (AEOI)
      bus_wr(1'b0, 8'h1B);
      chk("icw1_ltim", ltim, 1'b1);
      chk("icw1_done", init_done, 1'b0);
      bus_wr(1'b1, 8'h40);
      chk("icw2_done", init_done, 1'b0);
      bus_wr(1'b1, 8'h03);
      chk("icw4_done", init_done, 1'b1);
      chk("icw4_aeoi", aeoi, 1'b1);
      chk("icw4_im", im, 8'hFF);

      // OCW1 unmask all, then request on IR3
      bus_wr(1'b1, 8'h00);
      chk("ocw1_im", im, 8'h00);
      int_req = 1'b1; int_vec = 3'd3;
      chk("int_lat0", int_out, 1'b0);
      @(negedge clk);
      chk("int_lat1", int_out, 1'b1);

      // two-pulse INTA: vector {01000,011} on pulse 2 only; later vec change ignored
      pulse("p1", 2, 1'b0, 8'h00);
      int_vec = 3'd5;
      pulse("p2", 2, 1'b1, 8'h43);

      // OCW2 non-specific EOI is a one-cycle pulse
      bus_wr(1'b0, 8'h20);
      chk("eoi_op", operation, 8'h20);
      @(negedge clk);
      chk("eoi_clr", operation, 8'h00);

      // OCW2 rotate command persists
      bus_wr(1'b0, 8'h80);
      chk("rot_op", operation, 8'h80);
      repeat (20) @(negedge clk);
      chk("rot_hold", operation, 8'h80);

      // abort mid-INTA with ICW1
      int_vec = 3'd3;
      pulse("ab_p1", 2, 1'b0, 8'h00);
      bus_wr(1'b0, 8'h1B);
      chk("ab_done", init_done, 1'b0);
      chk("ab_im", im, 8'hFF);
      chk("ab_op", operation, 8'h00);
      chk("ab_aeoi", aeoi, 1'b0);
      @(negedge clk);
      chk("ab_int", int_out, 1'b0);
      pulse("ab_p2", 2, 1'b0, 8'h00);
      bus_wr(1'b1, 8'h40);
      bus_wr(1'b1, 8'h03);
      chk("reinit_done", init_done, 1'b1);
      // sequencer restarted from idle: first pulse latches, second drives
      pulse("re_p1", 2, 1'b0, 8'h00);
      int_vec = 3'd6;
      pulse("re_p2", 3, 1'b1, 8'h43);

      // ICW1 11: cascade with ICW4; ICW3 step must be consumed
      bus_wr(1'b0, 8'h11);
      chk("c_ltim", ltim, 1'b0);
      bus_wr(1'b1, 8'h48);
      chk("c_icw2_done", init_done, 1'b0);
      pulse("c_pa", 2, 1'b0, 8'h00);
      pulse("c_pb", 2, 1'b0, 8'h00);
      bus_wr(1'b1, 8'hAA);
      chk("c_icw3_done", init_done, 1'b0);
      bus_wr(1'b1, 8'h01);
      chk("c_icw4_done", init_done, 1'b1);
      chk("c_aeoi", aeoi, 1'b0);

      // ICW1 1A: single, no ICW4 -> ready right after ICW2, aeoi cleared
      bus_wr(1'b0, 8'h1A);
      bus_wr(1'b1, 8'h48);
      chk("s_done", init_done, 1'b1);
      chk("s_aeoi", aeoi, 1'b0);

      // status readback
      bus_wr(1'b1, 8'h5A);
      irr = 8'h21; isr = 8'h08;
`ifdef PIC_READBACK_EN
      bus_wr(1'b0, 8'h0B);
      @(negedge clk); rd = 1'b1; a0 = 1'b0;
      @(negedge clk); rd = 1'b0;
      chk("rb_isr_en", dout_en, 1'b1);
      chk("rb_isr", dout, 8'h08);
      @(negedge clk);
      chk("rb_isr_1cyc", dout_en, 1'b0);
      bus_wr(1'b0, 8'h0A);
      @(negedge clk); rd = 1'b1; a0 = 1'b0;
      @(negedge clk); rd = 1'b0;
      chk("rb_irr", dout, 8'h21);
      @(negedge clk); rd = 1'b1; a0 = 1'b1;
      @(negedge clk); rd = 1'b0;
      chk("rb_im_en", dout_en, 1'b1);
      chk("rb_im", dout, 8'h5A);
`else
      @(negedge clk); rd = 1'b1; a0 = 1'b1;
      @(negedge clk); rd = 1'b0;
      chk("rb_off_en", dout_en, 1'b0);
      chk("rb_off_dout", dout, 8'h00);
`endif
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pic_control_sequencer.md
Name: pic_control_sequencer

Overview:
- Command/acknowledge controller for the 8259A PIC; sits between the CPU-side bus interface and priority_resolver.
- Runs the ICW1–ICW4 initialisation state machine and decodes OCW1–OCW3.
- Drives the resolver's IM/operation/LTIM/AEOI configuration.
- Sequences the 8086-mode two-pulse INTA cycle, placing the interrupt vector on the data bus during the second pulse.

Parameters:
- VEC_W, 3, width of the resolver vector index (int_vec); fixed at 3 for 8 IR lines.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr  in  1  one-cycle write strobe from bus interface
- rd  in  1  one-cycle read strobe (status read)
- a0  in  1  address bit A0
- din  in  8  write data
- inta  in  1  interrupt acknowledge, active high, already synchronised to clk
- int_req  in  1  INT from priority_resolver
- int_vec  in  3  INT_VEC from priority_resolver
- irr  in  8  IRR from priority_resolver
- isr  in  8  ISR from priority_resolver
- im  out  8  mask to resolver IM (OCW1)
- operation  out  8  OCW2-format command to resolver
- ltim  out  1  level-trigger mode (ICW1 bit3)
- aeoi  out  1  automatic EOI (ICW4 bit1)
- int_out  out  1  INT to CPU
- dout  out  8  data bus output
- dout_en  out  1  dout valid / drive enable
- init_done  out  1  initialisation complete

Behaviour:
- All regs update on posedge clk. Reset (rst=1) state:
  - im=8'hFF, operation=0, ltim=0, aeoi=0, int_out=0, dout=0, dout_en=0, init_done=0.
  - Both FSMs to idle; T-base=0; read select = IRR.
- Init FSM: UNINIT -> WAIT_ICW2 -> [WAIT_ICW3] -> [WAIT_ICW4] -> READY.
  - UNINIT: wr & a0=0 & din[4]=1 is ICW1; capture LTIM=din[3], SNGL=din[1], IC4=din[0]; next WAIT_ICW2. Other writes are ignored.
  - WAIT_ICW2: wr & a0=1 captures T[7:3]=din[7:3]. Next: WAIT_ICW3 if SNGL=0; else WAIT_ICW4 if IC4=1; else READY.
  - WAIT_ICW3: wr & a0=1 captures the cascade byte (stored, unused). Next: WAIT_ICW4 if IC4, else READY.
  - WAIT_ICW4: wr & a0=1 captures aeoi=din[1]; next READY. If IC4=0, aeoi=0.
  - An ICW1 write in any state restarts at WAIT_ICW2 and resets im=8'hFF, operation=0, aeoi=0, init_done=0, and the INTA FSM.
  - init_done=1 only in READY. ltim updates on the ICW1 capture cycle.
- READY decode:
  - a0=1: OCW1; im<=din next cycle.
  - a0=0, din[4:3]=00: OCW2.
    - din[5]=1 (EOI types): operation=din for exactly one cycle, then 0.
    - din[5]=0 (rotate-mode set/clear, set priority): operation=din, held until the next OCW2 or ICW1.
  - a0=0, din[4:3]=01: OCW3; if din[1]=1, read select<=din[0] (0=IRR, 1=ISR).
- int_out = int_req registered, forced 0 unless READY; 1-cycle latency.
- INTA FSM (rising edge = inta & ~inta_q): A_IDLE -> A_P1 -> A_P2 -> A_IDLE.
  - A_IDLE, edge: latch int_vec; go A_P1; no drive.
  - A_P1, edge: dout={T[7:3],latched vec}, dout_en=1 while inta=1; go A_P2.
  - A_P2, inta falling: dout_en=0, dout=0; A_IDLE.
  - int_vec is latched only on the first pulse; a later resolver change does not alter the vector.
  - INTA edges before READY are ignored.
  - Same-cycle wr and INTA edge: the write is processed. If it is ICW1, it aborts the INTA sequence; otherwise both proceed.
- dout_en is never asserted by rd in the same cycle as an INTA drive; INTA has priority.

Optional Feature:
- PIC_READBACK_EN.
  - Defined: rd in READY with no INTA drive gives, next cycle, dout_en=1 for one cycle.
    - a0=1: dout=im.
    - a0=0: dout=irr or isr per read select.
  - Undefined: rd, irr and isr are ignored; dout is driven only by INTA.

Decomposition:
- Shared package holds:
  - init FSM and INTA FSM state encodings.
  - OCW2 field positions (R=7, SL=6, EOI=5, L=2:0).
  - ICW1 bit positions (ICW1 flag=4, LTIM=3, SNGL=1, IC4=0).
  - OCW3 RR/RIS bits and the IMR reset constant 8'hFF.
- One natural sub-module: pic_inta_sequencer (edge detect, vector latch, dout drive).

Test Plan:
- Init with ICW1=8'h1B, ICW2=8'h40, ICW4=8'h03 -> init_done=1 after ICW4; ltim=1, aeoi=1, ICW3 skipped, im=8'hFF.
- READY, OCW1 a0=1 din=8'h00, then int_req=1 with int_vec=3 -> im=0; int_out=1 one cycle later; two inta pulses -> second pulse dout=8'h43, dout_en=1 only during pulse 2.
- OCW2 din=8'h20 -> operation=8'h20 for exactly one cycle, then 0; OCW2 din=8'h80 -> operation holds 8'h80 across 20 cycles.
- Mid-INTA (after pulse 1), ICW1 write -> INTA FSM idle, dout_en stays 0 on next inta, init_done=0, im=8'hFF.
- ICW1=8'h11 (SNGL=0, IC4=1) -> FSM visits WAIT_ICW3 then WAIT_ICW4; INTA pulses during init produce no dout_en.
- With PIC_READBACK_EN: OCW3 din=8'h0B, rd a0=0 with isr=8'h08 -> dout=8'h08 for one cycle; rd a0=1 -> dout=im.
